// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Renderer-facing raster bus and board VGA pins of vga_timing_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CNT_W   = 10,
    parameter int COLOR_W = 12
);
    logic [COLOR_W-1:0]   color;
    logic                 p_tick;
    logic [CNT_W-1:0]     x_pos;
    logic [CNT_W-1:0]     y_pos;
    logic                 active;
    logic                 line_start;
    logic                 frame_start;
    logic                 Hsync;
    logic                 Vsync;
    logic [COLOR_W/3-1:0] vgaRed;
    logic [COLOR_W/3-1:0] vgaGreen;
    logic [COLOR_W/3-1:0] vgaBlue;

    // Master is the timing generator; slave is the renderer plus pin side.
    modport master (
        input  color,
        output p_tick, x_pos, y_pos, active, line_start, frame_start,
        output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue
    );

    modport slave (
        output color,
        input  p_tick, x_pos, y_pos, active, line_start, frame_start,
        input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with pixel enable,
//               configurable-polarity sync and blanked, registered colour.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_PW      = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_PW      = 2,
    parameter int V_BP      = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int COLOR_W   = 12,
    parameter int CNT_W     = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_timing_gen_if.master bus
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FP + H_PW + H_BP;
    localparam int c_V_TOTAL = V_DISPLAY + V_FP + V_PW + V_BP;
    localparam int c_CW      = COLOR_W / 3;

    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_DISP   = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] c_V_DISP   = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_DISPLAY + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_DISPLAY + H_FP + H_PW);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_DISPLAY + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_DISPLAY + V_FP + V_PW);

    // Sync-region end bounds are compared at CNT_W, so they must not wrap.
    generate
        if (CLK_DIV < 1 || (COLOR_W % 3) != 0 || COLOR_W < 3 ||
            H_DISPLAY < 1 || V_DISPLAY < 1 ||
            (H_DISPLAY + H_FP + H_PW) >= (1 << CNT_W) ||
            (V_DISPLAY + V_FP + V_PW) >= (1 << CNT_W) ||
            c_H_TOTAL > (1 << CNT_W) || c_V_TOTAL > (1 << CNT_W)) begin : g_bad_params
            $error("vga_timing_gen: illegal parameter combination");
        end
    endgenerate

    logic                 w_p_tick;
    logic [CNT_W-1:0]     r_x;
    logic [CNT_W-1:0]     r_y;
    logic                 r_hsync;
    logic                 r_vsync;
    logic [COLOR_W-1:0]   r_rgb;
    logic                 w_active;
    logic                 w_line_start;
    logic                 w_h_sync_region;
    logic                 w_v_sync_region;

    // ------------------------------------------------------------------------
    // Pixel clock-enable
    // ------------------------------------------------------------------------
    generate
        if (CLK_DIV == 1) begin : g_div_bypass
            assign w_p_tick = 1'b1;
        end else begin : g_div_count
            localparam int c_DIV_W = $clog2(CLK_DIV);
            localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

            logic [c_DIV_W-1:0] r_div;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_div <= '0;
                end else if (r_div == c_DIV_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + c_DIV_W'(1);
                end
            end

            assign w_p_tick = (r_div == c_DIV_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_p_tick) begin
            if (r_x == c_H_LAST) begin
                r_x <= '0;
                if (r_y == c_V_LAST) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + CNT_W'(1);
                end
            end else begin
                r_x <= r_x + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status decode
    // ------------------------------------------------------------------------
    assign w_active        = (r_x < c_H_DISP) && (r_y < c_V_DISP);
    assign w_line_start    = w_p_tick && (r_x == '0);
    assign w_h_sync_region = (r_x >= c_HS_START) && (r_x < c_HS_END);
    assign w_v_sync_region = (r_y >= c_VS_START) && (r_y < c_VS_END);

    // ------------------------------------------------------------------------
    // Pixel outputs: one pixel period behind the counters, mutually aligned
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_rgb   <= '0;
        end else if (w_p_tick) begin
            r_hsync <= w_h_sync_region ? H_POL : ~H_POL;
            r_vsync <= w_v_sync_region ? V_POL : ~V_POL;
            r_rgb   <= w_active ? bus.color : '0;
        end
    end

    assign bus.p_tick      = w_p_tick;
    assign bus.x_pos       = r_x;
    assign bus.y_pos       = r_y;
    assign bus.active      = w_active;
    assign bus.line_start  = w_line_start;
    assign bus.frame_start = w_line_start && (r_y == '0);
    assign bus.Hsync       = r_hsync;
    assign bus.Vsync       = r_vsync;
    assign bus.vgaRed      = r_rgb[COLOR_W-1 -: c_CW];
    assign bus.vgaGreen    = r_rgb[COLOR_W-c_CW-1 -: c_CW];
    assign bus.vgaBlue     = r_rgb[c_CW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen (default, tiny, medium).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_s, rst_m;

    vga_timing_gen_if #(.CNT_W(10), .COLOR_W(12)) bus ();
    vga_timing_gen #(
        .CLK_DIV(4), .H_DISPLAY(640), .H_FP(16), .H_PW(96), .H_BP(48),
        .V_DISPLAY(480), .V_FP(10), .V_PW(2), .V_BP(33),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(12), .CNT_W(10)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // Tiny raster: 12 x 7, one clock per pixel, active-high syncs.
    vga_timing_gen_if #(.CNT_W(4), .COLOR_W(3)) bus_s ();
    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FP(1), .H_PW(2), .H_BP(1),
        .V_DISPLAY(4), .V_FP(1), .V_PW(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(3), .CNT_W(4)
    ) dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

    // Medium raster: 24 x 12, two clocks per pixel, so a whole frame is 576 clocks.
    vga_timing_gen_if #(.CNT_W(5), .COLOR_W(6)) bus_m ();
    vga_timing_gen #(
        .CLK_DIV(2), .H_DISPLAY(16), .H_FP(2), .H_PW(3), .H_BP(3),
        .V_DISPLAY(6), .V_FP(2), .V_PW(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(6), .CNT_W(5)
    ) dut_m (.clk(clk), .rst(rst_m), .bus(bus_m));

    typedef struct {
        logic [9:0] x;
        logic [3:0] tick_pat;
        logic       fs;
    } cad_vec_t;

    typedef struct {
        logic [3:0] x;
        logic       hs;
        logic       ls;
    } small_vec_t;

    cad_vec_t   cad [10];
    small_vec_t sv  [14];

    int checks   = 0;
    int failures = 0;

    int         found, prev, tick_err, rgb_err, hs_err, hs_low, hs_first, ls_cnt, ls_last;
    int         fs_cnt, vs_cnt, vs_first, vs_first_y, wraps, wrap_err, have_prev;
    int         ls_k [2];
    int         fs_k [2];
    logic [11:0] exp_rgb;
    logic [4:0] prev_x, prev_y;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cad[0] = '{10'd0, 4'b1000, 1'b1};
        cad[1] = '{10'd1, 4'b1000, 1'b0};
        cad[2] = '{10'd2, 4'b1000, 1'b0};
        cad[3] = '{10'd3, 4'b1000, 1'b0};
        cad[4] = '{10'd4, 4'b1000, 1'b0};
        cad[5] = '{10'd5, 4'b1000, 1'b0};
        cad[6] = '{10'd6, 4'b1000, 1'b0};
        cad[7] = '{10'd7, 4'b1000, 1'b0};
        cad[8] = '{10'd8, 4'b1000, 1'b0};
        cad[9] = '{10'd9, 4'b1000, 1'b0};

        // Tiny raster, clocks after reset release: hsync shows x 9..10 one clock late.
        sv[0]  = '{4'd0,  1'b0, 1'b1};
        sv[1]  = '{4'd1,  1'b0, 1'b0};
        sv[2]  = '{4'd2,  1'b0, 1'b0};
        sv[3]  = '{4'd3,  1'b0, 1'b0};
        sv[4]  = '{4'd4,  1'b0, 1'b0};
        sv[5]  = '{4'd5,  1'b0, 1'b0};
        sv[6]  = '{4'd6,  1'b0, 1'b0};
        sv[7]  = '{4'd7,  1'b0, 1'b0};
        sv[8]  = '{4'd8,  1'b0, 1'b0};
        sv[9]  = '{4'd9,  1'b0, 1'b0};
        sv[10] = '{4'd10, 1'b1, 1'b0};
        sv[11] = '{4'd11, 1'b1, 1'b0};
        sv[12] = '{4'd0,  1'b0, 1'b1};
        sv[13] = '{4'd1,  1'b0, 1'b0};

        rst = 1'b0; rst_s = 1'b0; rst_m = 1'b0;
        bus.color   = 12'hFFF;
        bus_s.color = 3'b111;
        bus_m.color = 6'h3F;

        #1 rst = 1'b1; rst_s = 1'b1; rst_m = 1'b1;
        #1;
        check("reset_before_clock_x", 32'(bus.x_pos), 32'd0);
        check("reset_before_clock_hsync", 32'(bus.Hsync), 32'd1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_x", 32'(bus.x_pos), 32'd0);
        check("reset_y", 32'(bus.y_pos), 32'd0);
        check("reset_hsync", 32'(bus.Hsync), 32'd1);
        check("reset_vsync", 32'(bus.Vsync), 32'd1);
        check("reset_rgb", 32'({bus.vgaRed, bus.vgaGreen, bus.vgaBlue}), 32'd0);
        check("reset_p_tick", 32'(bus.p_tick), 32'd0);
        check("reset_active", 32'(bus.active), 32'd1);
        check("reset_frame_start", 32'(bus.frame_start), 32'd0);

        // Pixel cadence directly after release.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                check("cadence_x", 32'(bus.x_pos), 32'(cad[i].x));
                check("cadence_p_tick", 32'(bus.p_tick), 32'(cad[i].tick_pat[j]));
                check("cadence_frame_start", 32'(bus.frame_start),
                      32'(cad[i].fs && cad[i].tick_pat[j]));
                tick();
            end
        end

        // One full line of constant colour, starting at line 1.
        bus.color = 12'hABC;
        found = 0;
        for (int n = 0; n < 5000 && found == 0; n++) begin
            if (bus.p_tick === 1'b1 && bus.x_pos == 10'd0 && bus.y_pos == 10'd1) found = 1;
            else tick();
        end
        check("find_line1", 32'(found), 32'd1);

        tick_err = 0; rgb_err = 0; hs_err = 0; hs_low = 0; hs_first = -1;
        ls_cnt = 0; ls_last = -1;
        for (int c = 0; c <= 3200; c++) begin
            if (bus.line_start === 1'b1) begin
                ls_cnt++;
                ls_last = c;
            end
            if (bus.p_tick !== ((c % 4) == 0)) tick_err++;
            if ((c % 4) == 0) begin
                prev    = (c == 0) ? 799 : c / 4 - 1;
                exp_rgb = (prev < 640) ? 12'hABC : 12'h000;
                if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== exp_rgb) rgb_err++;
                if (bus.Hsync !== ((prev >= 656 && prev < 752) ? 1'b0 : 1'b1)) hs_err++;
                if (bus.Hsync === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(bus.x_pos);
                end
                if (c == 4) begin
                    check("line_red", 32'(bus.vgaRed), 32'hA);
                    check("line_green", 32'(bus.vgaGreen), 32'hB);
                    check("line_blue", 32'(bus.vgaBlue), 32'hC);
                end
            end
            if (c < 3200) tick();
        end
        check("line_tick_errors", 32'(tick_err), 32'd0);
        check("line_rgb_errors", 32'(rgb_err), 32'd0);
        check("line_hsync_errors", 32'(hs_err), 32'd0);
        check("line_hsync_low_pixels", 32'(hs_low), 32'd96);
        check("line_hsync_first_low_x", 32'(hs_first), 32'd657);
        check("line_start_count", 32'(ls_cnt), 32'd2);
        check("line_start_period", 32'(ls_last), 32'd3200);
        check("line_wrap_y", 32'(bus.y_pos), 32'd2);

        // Asynchronous reset in the middle of a visible line.
        found = 0;
        for (int n = 0; n < 2000 && found == 0; n++) begin
            if (bus.p_tick === 1'b1 && bus.x_pos == 10'd300) found = 1;
            else tick();
        end
        check("find_x300", 32'(found), 32'd1);
        check("pre_reset_y", 32'(bus.y_pos), 32'd2);
        check("pre_reset_rgb", 32'({bus.vgaRed, bus.vgaGreen, bus.vgaBlue}), 32'hABC);
        #2 rst = 1'b1;
        #1;
        check("async_rst_x", 32'(bus.x_pos), 32'd0);
        check("async_rst_y", 32'(bus.y_pos), 32'd0);
        check("async_rst_rgb", 32'({bus.vgaRed, bus.vgaGreen, bus.vgaBlue}), 32'd0);
        check("async_rst_hsync", 32'(bus.Hsync), 32'd1);
        check("async_rst_vsync", 32'(bus.Vsync), 32'd1);
        check("async_rst_p_tick", 32'(bus.p_tick), 32'd0);
        check("async_rst_line_start", 32'(bus.line_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("restart_x", 32'(bus.x_pos), 32'd0);
        check("restart_p_tick", 32'(bus.p_tick), 32'd0);
        tick(); tick(); tick();
        check("restart_p_tick_3", 32'(bus.p_tick), 32'd1);
        check("restart_frame_start", 32'(bus.frame_start), 32'd1);
        check("restart_y", 32'(bus.y_pos), 32'd0);
        tick();
        check("restart_x_next", 32'(bus.x_pos), 32'd1);
        check("restart_frame_start_width", 32'(bus.frame_start), 32'd0);

        // Tiny raster: constant pixel enable, table-driven first line, then frame metrics.
        check("small_reset_p_tick", 32'(bus_s.p_tick), 32'd1);
        check("small_reset_hsync", 32'(bus_s.Hsync), 32'd0);
        check("small_reset_vsync", 32'(bus_s.Vsync), 32'd0);
        rst_s = 1'b0;
        #1;
        tick_err = 0; ls_cnt = 0; fs_cnt = 0; vs_cnt = 0; vs_first = -1;
        ls_k[0] = -1; ls_k[1] = -1; fs_k[0] = -1; fs_k[1] = -1;
        for (int k = 0; k < 168; k++) begin
            if (k < 14) begin
                check("small_x", 32'(bus_s.x_pos), 32'(sv[k].x));
                check("small_hsync", 32'(bus_s.Hsync), 32'(sv[k].hs));
                check("small_line_start", 32'(bus_s.line_start), 32'(sv[k].ls));
            end
            if (bus_s.p_tick !== 1'b1) tick_err++;
            if (bus_s.line_start === 1'b1) begin
                if (ls_cnt < 2) ls_k[ls_cnt] = k;
                ls_cnt++;
            end
            if (bus_s.frame_start === 1'b1) begin
                if (fs_cnt < 2) fs_k[fs_cnt] = k;
                fs_cnt++;
            end
            if (bus_s.Vsync === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k;
            end
            if (k == 83) begin
                check("small_last_x", 32'(bus_s.x_pos), 32'd11);
                check("small_last_y", 32'(bus_s.y_pos), 32'd6);
            end
            if (k == 84) begin
                check("small_wrap_x", 32'(bus_s.x_pos), 32'd0);
                check("small_wrap_y", 32'(bus_s.y_pos), 32'd0);
            end
            tick();
        end
        check("small_p_tick_errors", 32'(tick_err), 32'd0);
        check("small_line_count", 32'(ls_cnt), 32'd14);
        check("small_line_period", 32'(ls_k[1] - ls_k[0]), 32'd12);
        check("small_frame_count", 32'(fs_cnt), 32'd2);
        check("small_frame_first", 32'(fs_k[0]), 32'd0);
        check("small_frame_period", 32'(fs_k[1] - fs_k[0]), 32'd84);
        check("small_vsync_high_clocks", 32'(vs_cnt), 32'd24);
        check("small_vsync_first_high", 32'(vs_first), 32'd61);

        // Medium raster: two full frames for vertical sync and frame wrap.
        rst_m = 1'b0;
        #1;
        tick_err = 0; ls_cnt = 0; fs_cnt = 0; vs_cnt = 0; vs_first = -1; vs_first_y = -1;
        wraps = 0; wrap_err = 0; have_prev = 0; fs_k[0] = -1; fs_k[1] = -1;
        prev_x = '0; prev_y = '0;
        for (int k = 0; k <= 1160; k++) begin
            if (bus_m.p_tick !== ((k % 2) == 1)) tick_err++;
            if (bus_m.frame_start === 1'b1) begin
                if (fs_cnt < 2) fs_k[fs_cnt] = k;
                fs_cnt++;
            end
            if (bus_m.line_start === 1'b1 && k >= 1 && k <= 1152) ls_cnt++;
            if (bus_m.p_tick === 1'b1) begin
                if (k <= 1152 && bus_m.Vsync === 1'b0) begin
                    vs_cnt++;
                    if (vs_first < 0) begin
                        vs_first   = int'(bus_m.x_pos);
                        vs_first_y = int'(bus_m.y_pos);
                    end
                end
                if (have_prev == 1 && prev_x == 5'd23 && prev_y == 5'd11) begin
                    wraps++;
                    if (bus_m.x_pos !== 5'd0 || bus_m.y_pos !== 5'd0) wrap_err++;
                end
                prev_x    = bus_m.x_pos;
                prev_y    = bus_m.y_pos;
                have_prev = 1;
            end
            tick();
        end
        check("med_p_tick_errors", 32'(tick_err), 32'd0);
        check("med_frame_start_clocks", 32'(fs_cnt), 32'd3);
        check("med_frame_first", 32'(fs_k[0]), 32'd1);
        check("med_frame_period", 32'(fs_k[1] - fs_k[0]), 32'd576);
        check("med_line_start_clocks", 32'(ls_cnt), 32'd24);
        check("med_vsync_low_pixels", 32'(vs_cnt), 32'd96);
        check("med_vsync_first_x", 32'(vs_first), 32'd1);
        check("med_vsync_first_y", 32'(vs_first_y), 32'd8);
        check("med_wraps_seen", 32'(wraps), 32'd2);
        check("med_wrap_errors", 32'(wrap_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It derives a pixel clock-enable from the system clock, runs horizontal and vertical counters with fully parametrised porch, sync and display widths, and generates configurable-polarity sync signals. It registers the colour input with blanking applied outside the visible area. It replaces the fixed 640x480 generator and sits between the game renderer, which consumes `x_pos`/`y_pos`/`p_tick` and supplies `color`, and the board VGA pins.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; must be ≥1.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_PW`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_PW`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: hsync asserted level (0 = active-low).
- `V_POL`, 0: vsync asserted level.
- `COLOR_W`, 12: total colour width; must be a multiple of 3.
- `CNT_W`, 10: counter width; must hold `H_TOTAL-1` and `V_TOTAL-1`.

Derived: `H_TOTAL = H_DISPLAY+H_FP+H_PW+H_BP` (800), `V_TOTAL = V_DISPLAY+V_FP+V_PW+V_BP` (525).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous active-high reset.
- `color`  in  COLOR_W  pixel colour for the current `x_pos`/`y_pos`, as {R,G,B}.
- `p_tick`  out  1  pixel clock-enable, high for one `clk` every `CLK_DIV` clocks.
- `x_pos`  out  CNT_W  current horizontal count, 0..H_TOTAL-1.
- `y_pos`  out  CNT_W  current vertical count, 0..V_TOTAL-1.
- `active`  out  1  current count is inside the visible area.
- `line_start`  out  1  one-`clk` pulse at the start of each line.
- `frame_start`  out  1  one-`clk` pulse at the start of each frame.
- `Hsync`  out  1  registered hsync.
- `Vsync`  out  1  registered vsync.
- `vgaRed`, `vgaGreen`, `vgaBlue`  out  COLOR_W/3 each  registered, blanked colour.

## Operation
- **Divider:** `div` counts 0..CLK_DIV-1 and wraps.
  - `p_tick = (div == CLK_DIV-1)`, combinational.
  - If `CLK_DIV=1`, `p_tick` is constant 1 out of reset.
- **Counters:** all counter and output registers update only on cycles where `p_tick` is high.
  - `x_pos` increments each `p_tick`.
  - At `x_pos == H_TOTAL-1`, `x_pos` wraps to 0 and `y_pos` increments.
  - At `y_pos == V_TOTAL-1` together with `x_pos == H_TOTAL-1`, both wrap to 0.
- **Combinational status:**
  - `active = x_pos < H_DISPLAY && y_pos < V_DISPLAY`.
  - `line_start = p_tick && x_pos == 0`.
  - `frame_start = line_start && y_pos == 0`.
- **Sync:**
  - Horizontal sync region: `H_DISPLAY+H_FP ≤ x_pos < H_DISPLAY+H_FP+H_PW` (656..751 at defaults).
  - Vertical sync region: `V_DISPLAY+V_FP ≤ y_pos < V_DISPLAY+V_FP+V_PW` (490..491 at defaults).
  - On `p_tick`, `Hsync` is loaded with `H_POL` inside the region and `!H_POL` outside. `Vsync` is loaded the same way using `V_POL`.
- **Colour:** on `p_tick`, `{vgaRed,vgaGreen,vgaBlue}` is loaded with `active ? color : 0`.
- **Arithmetic:** all comparisons are unsigned at `CNT_W`, with region bounds computed from parameters at elaboration time. No runtime arithmetic beyond the increments.
- **Reset:** `rst` asynchronously clears, with no dependence on `clk`:
  - `div`, `x_pos`, `y_pos` → 0.
  - Colour outputs → 0.
  - `Hsync` → `!H_POL`, `Vsync` → `!V_POL`.
  - Consequently during reset: `p_tick` = 0 (or 1 if `CLK_DIV=1`), `active` = 1, `line_start` and `frame_start` equal `p_tick`.
  - A reset mid-frame abandons the frame; the next frame restarts at (0,0).

## Timing
- The first `p_tick` occurs CLK_DIV-1 clocks after reset release. `frame_start` is high in that same cycle.
- `x_pos`/`y_pos` change on the `clk` edge that ends a `p_tick` cycle. They are stable for `CLK_DIV` clocks.
- **Colour contract:** the renderer must present `color` for the displayed (`x_pos`,`y_pos`) no later than the `p_tick` cycle.
- Pixel outputs (`vga*`, `Hsync`, `Vsync`) lag `x_pos`/`y_pos` by exactly one pixel period. They are mutually aligned.
- Line period is `H_TOTAL*CLK_DIV` clocks (3200). Frame period is `H_TOTAL*V_TOTAL*CLK_DIV` clocks (1,680,000).
- `line_start` and `frame_start` are exactly one `clk` wide for any `CLK_DIV` > 1.

## Test plan
- **Reset:** hold `rst` for 5 clocks with `color`=FFF.
  - During reset: `x_pos`=`y_pos`=0, `Hsync`=`Vsync`=1, RGB=0, `p_tick`=0.
  - After release: first `p_tick` exactly 3 clocks later, coinciding with `frame_start`=1.
- **Pixel cadence:** run 40 clocks after reset.
  - `p_tick` high on every 4th clock only.
  - `x_pos` reads 0,1,2,…,9 with each value held for 4 clocks.
- **Horizontal sync and blanking:** `color`=ABC held constant over one full line.
  - RGB = A,B,C for the pixel periods following `x_pos` 0..639, and 0 after 640..799.
  - `Hsync` low for exactly 96 pixel periods, starting one pixel period after `x_pos` reaches 656.
  - `line_start` pulses once per 3200 clocks.
- **Vertical sync and frame wrap:** run one full frame.
  - `Vsync` low for exactly 2 lines, starting after line 490.
  - `x_pos` 799 with `y_pos` 524 is followed by 0,0.
  - `frame_start` is seen exactly once per 1,680,000 clocks.
- **Small-parameter variant:** `CLK_DIV`=1, `H_POL`=`V_POL`=1, H=8/1/2/1, V=4/1/1/1.
  - `p_tick` constant 1.
  - `Hsync` high for exactly 2 clocks at `x_pos` 9..10, delayed by one clock.
  - Line period 12 clocks, frame period 84 clocks.
- **Asynchronous reset mid-frame:** assert `rst` at `x_pos`=300, `y_pos`=200, away from any clock edge.
  - Outputs return to reset values immediately, before the next `clk` edge.
  - After release, counting restarts at (0,0) with a `frame_start`.
